apb_slave_regfile: RTL and testbench
====================================

# apb_slave_regfile

APB completer (slave) holding a 16 x 32-bit register window, placed directly downstream of the day16 APB requester. It decodes the requester's fixed address 0xDEAD_CAFE into register 15, inserts a programmable number of wait states, and returns read data and PSLVERR. Two low registers are read-only: an ID word and a count of completed transfers.

## Interface
- `BASE_ADDR`, default 32'hDEAD_CAC0: window base; only bits [31:6] are compared.
- `WAIT_STATES`, default 1: number of access-phase cycles with `pready_o`=0 before completion (0..15).
- `ID_VALUE`, default 32'hA5B0_0016: read value of register 0.
- `clk` in 1: clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `psel_i` in 1: APB select.
- `penable_i` in 1: APB enable, access phase.
- `paddr_i` in 32: byte address.
- `pwrite_i` in 1: 1 = write, 0 = read.
- `pwdata_i` in 32: write data.
- `pready_o` out 1: transfer-complete strobe (registered).
- `prdata_o` out 32: read data; valid only while `pready_o`=1, otherwise 0.
- `pslverr_o` out 1: error response; valid only while `pready_o`=1, otherwise 0.

## Operation
- **Address decode.** The address is in the window when `paddr_i[31:6]` == `BASE_ADDR[31:6]`. The register index is `paddr_i[5:2]`; `paddr_i[1:0]` is ignored. So 0xDEAD_CAFE selects index 15.
- **Register map:**
  - reg0 = `ID_VALUE`, read-only.
  - reg1 = transfer counter, read-only.
  - reg2..reg15 are read/write, reset to 0.
- **Error cases.** `pslverr_o` is set for either of:
  - an out-of-window address (a read returns 0);
  - a write to reg0 or reg1.
  An errored write changes no register.
- **FSM states:** ST_IDLE, ST_WAIT, ST_READY.
  - ST_IDLE: on a setup cycle (`psel_i`=1, `penable_i`=0):
    - capture `paddr_i`, `pwrite_i`, `pwdata_i` into hold registers;
    - if `WAIT_STATES`=0, go to ST_READY; otherwise load `wcnt` = `WAIT_STATES`-1 and go to ST_WAIT.
    - `penable_i`=1 without a preceding setup is ignored (stay in IDLE, no response).
  - ST_WAIT: if `psel_i`=0, abort to ST_IDLE. Else if `wcnt`=0, go to ST_READY. Else decrement `wcnt`.
  - ST_READY: `pready_o`=1. Leave for ST_IDLE unconditionally after one cycle. If `psel_i`=0 in this cycle, the transfer is aborted: no write, no count.
- **Completion:** `psel_i` & `penable_i` & `pready_o`.
  - On completion, a non-error write stores the held `pwdata` into the held index.
  - On completion, reg1 increments by 1, including errored transfers. It wraps 0xFFFF_FFFF -> 0.
- **Captured values.** Address, direction and write data are the values captured in the setup cycle. Changes during the access phase are ignored.
- **Read data.** `prdata_o` and `pslverr_o` are computed from the held address when entering ST_READY. They are cleared to 0 when leaving ST_READY.
- **Reading reg1.** A read of reg1 returns the count before the current transfer is added.

## Timing
- **Reset.** Synchronous reset gives:
  - state = ST_IDLE and `wcnt` = 0;
  - `pready_o` = 0, `prdata_o` = 0, `pslverr_o` = 0;
  - reg1..reg15 = 0, hold registers = 0.
  Reset mid-transfer abandons the transfer; no write occurs on that edge.
- **Latency.** The setup cycle is T0. `pready_o` rises in cycle T0+1+`WAIT_STATES`, for exactly one cycle.
  - `WAIT_STATES`=0 gives a zero-wait transfer: `pready_o`=1 in the first access cycle.
  - The default of 1 gives one stalled access cycle.
- **Write commit.** A register write is visible on the edge ending the completion cycle. A read issued in the next setup cycle returns the new value.
- **Back-to-back transfers.** A setup cycle immediately after completion is accepted: the FSM is in ST_IDLE that cycle.
- **Outputs.** No combinational path from any input to any output; all outputs are registered.

## Test plan
1. **Reset values.** Assert `reset` 2 cycles with random bus inputs -> all outputs 0. Then read reg1 -> 0; read reg15 -> 0.
2. **Write then read, default wait.** Write 0x0000_0001 to 0xDEAD_CAFE with `WAIT_STATES`=1 -> `pready_o` high exactly at T0+2, `pslverr_o`=0. Then read 0xDEAD_CAFE -> `prdata_o`=0x0000_0001. Then read reg1 (0xDEAD_CAC4) -> 2.
3. **Read/increment/write loop with the day16 requester.** Drive its commands read, write, read, write -> reg15 sequence 0 -> 1, read returns 1 -> 2. Every transfer completes with `pslverr_o`=0.
4. **Error cases.**
   - Write 0x1234 to 0xDEAD_CAC0 (ID register) -> `pslverr_o`=1; a subsequent read returns 0xA5B0_0016.
   - Read 0x0000_0000 -> `pslverr_o`=1, `prdata_o`=0.
   - reg1 still increments for both.
5. **Abort and reset mid-transfer.**
   - Drop `psel_i` in ST_WAIT during a write of 0xFFFF to reg2 -> no `pready_o`, reg2 stays 0, reg1 unchanged.
   - Separately, assert `reset` during ST_WAIT -> outputs 0 next cycle.
6. **Zero-wait and counter wrap.**
   - With `WAIT_STATES`=0, a back-to-back write/read of reg3 = 0xCAFE_F00D -> `pready_o` in the first access cycle of each transfer; the read returns 0xCAFE_F00D.
   - Force reg1 to 0xFFFF_FFFF, complete one transfer -> reads 0.

Source files
------------

// File: rtl/apb_slave_regfile.sv
// APB completer with a 16 x 32-bit register window: ID word, transfer counter,
// fourteen read/write registers, programmable wait states and PSLVERR.
module apb_slave_regfile #(
    parameter logic [31:0] BASE_ADDR   = 32'hDEAD_CAC0,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0016
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic [31:0] paddr_i,
    input  logic        pwrite_i,
    input  logic [31:0] pwdata_i,
    output logic        pready_o,
    output logic [31:0] prdata_o,
    output logic        pslverr_o,
    output logic [1:0]  state_o
);

    // Handshake: a setup cycle (psel_i=1, penable_i=0) starts a transfer; it completes
    // on the edge where psel_i, penable_i and pready_o are all 1. Dropping psel_i aborts.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  wcnt_q;
    logic [31:2] addr_q;
    logic        write_q;
    logic [31:0] wdata_q;
    logic [31:0] regs_q [2:15];
    logic [31:0] cnt_q;
    logic        pready_q;
    logic [31:0] prdata_q;
    logic        pslverr_q;

    logic [31:2] lk_addr;
    logic        lk_write;
    logic        lk_in_win;
    logic [3:0]  lk_idx;
    logic [31:0] prdata_d;
    logic        pslverr_d;
    logic [31:0] cnt_d;
    logic        setup;
    logic        complete;
    logic        wr_commit;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^paddr_i[1:0];
    assign setup     = psel_i & ~penable_i;
    assign complete  = psel_i & penable_i & pready_q;
    assign wr_commit = complete & write_q & (addr_q[31:6] == BASE_ADDR[31:6]) & (addr_q[5:2] > 4'd1);
    assign cnt_d     = cnt_q + 32'd1;

    // With zero wait states READY is entered straight from the setup cycle, before the
    // hold registers are loaded, so the lookup uses the live setup values there.
    always_comb begin
        lk_addr   = (state_q == ST_IDLE) ? paddr_i[31:2] : addr_q;
        lk_write  = (state_q == ST_IDLE) ? pwrite_i : write_q;
        lk_in_win = (lk_addr[31:6] == BASE_ADDR[31:6]);
        lk_idx    = lk_addr[5:2];
        pslverr_d = ~lk_in_win | (lk_write & (lk_idx < 4'd2));
        prdata_d  = '0;
        if (lk_in_win && !lk_write) begin
            if (lk_idx == 4'd0) begin
                prdata_d = ID_VALUE;
            end else if (lk_idx == 4'd1) begin
                prdata_d = cnt_q;
            end else begin
                for (int i = 2; i < 16; i++) begin
                    if (lk_idx == 4'(i)) prdata_d = regs_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            wcnt_q    <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (setup) begin
                        addr_q  <= paddr_i[31:2];
                        write_q <= pwrite_i;
                        wdata_q <= pwdata_i;
                        if (WAIT_STATES == 0) begin
                            state_q   <= ST_READY;
                            pready_q  <= 1'b1;
                            prdata_q  <= prdata_d;
                            pslverr_q <= pslverr_d;
                        end else begin
                            wcnt_q  <= 4'(WAIT_STATES - 1);
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!psel_i) begin
                        state_q <= ST_IDLE;
                    end else if (wcnt_q == 4'd0) begin
                        state_q   <= ST_READY;
                        pready_q  <= 1'b1;
                        prdata_q  <= prdata_d;
                        pslverr_q <= pslverr_d;
                    end else begin
                        wcnt_q <= wcnt_q - 4'd1;
                    end
                end
                ST_READY: begin
                    state_q   <= ST_IDLE;
                    pready_q  <= 1'b0;
                    prdata_q  <= '0;
                    pslverr_q <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Counter advances on every completion, errored or not; writes only when legal.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            for (int i = 2; i < 16; i++) regs_q[i] <= '0;
        end else if (complete) begin
            cnt_q <= cnt_d;
            if (wr_commit) begin
                for (int i = 2; i < 16; i++) begin
                    if (addr_q[5:2] == 4'(i)) regs_q[i] <= wdata_q;
                end
            end
        end
    end

    assign pready_o  = pready_q;
    assign prdata_o  = prdata_q;
    assign pslverr_o = pslverr_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: instance 0 uses one wait state, instance 1 none.
module tb_apb_slave_regfile;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        psel [2];
    logic        penable [2];
    logic        pwrite [2];
    logic [31:0] paddr [2];
    logic [31:0] pwdata [2];
    logic        pready_w [2];
    logic        pslverr_w [2];
    logic [31:0] prdata_w [2];
    logic [1:0]  state_w [2];

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] rd;
    logic        er;
    int          lat;

    always #5 clk = ~clk;

    apb_slave_regfile dut0 (
        .clk(clk), .reset(reset), .psel_i(psel[0]), .penable_i(penable[0]),
        .paddr_i(paddr[0]), .pwrite_i(pwrite[0]), .pwdata_i(pwdata[0]),
        .pready_o(pready_w[0]), .prdata_o(prdata_w[0]), .pslverr_o(pslverr_w[0]),
        .state_o(state_w[0])
    );

    apb_slave_regfile #(.WAIT_STATES(0)) dut1 (
        .clk(clk), .reset(reset), .psel_i(psel[1]), .penable_i(penable[1]),
        .paddr_i(paddr[1]), .pwrite_i(pwrite[1]), .pwdata_i(pwdata[1]),
        .pready_o(pready_w[1]), .prdata_o(prdata_w[1]), .pslverr_o(pslverr_w[1]),
        .state_o(state_w[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_zero();
        for (int d = 0; d < 2; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = '0;  pwdata[d] = '0;
        end
    endtask

    // Full transfer: setup, then access until pready; returns latency in cycles after T0.
    task automatic xfer(input int d, input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int latency);
        bit got = 0;
        rdata = '0; err = 1'b0; latency = 0;
        @(negedge clk);
        psel[d] = 1'b1; penable[d] = 1'b0; paddr[d] = addr; pwrite[d] = wr; pwdata[d] = wdata;
        for (int k = 1; k <= 16 && !got; k++) begin
            @(negedge clk);
            penable[d] = 1'b1;
            if (pready_w[d]) begin
                got = 1; latency = k; rdata = prdata_w[d]; err = pslverr_w[d];
            end
        end
        if (!got) begin
            check_eq("xfer_timeout", 32'd0, 32'd1);
            psel[d] = 1'b0; penable[d] = 1'b0;
        end
    endtask

    // Releases the bus after a completion; pready must already be low again.
    task automatic bus_idle(input int d);
        @(negedge clk);
        psel[d] = 1'b0; penable[d] = 1'b0;
        check_eq("idle_pready", {31'b0, pready_w[d]}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; bus_zero();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_zero();
        // Reset with random bus activity
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            for (int d = 0; d < 2; d++) begin
                psel[d] = 1'($urandom_range(0, 1)); penable[d] = 1'($urandom_range(0, 1));
                pwrite[d] = 1'($urandom_range(0, 1)); paddr[d] = $urandom; pwdata[d] = $urandom;
            end
            @(negedge clk);
            check_eq("rst_pready0", {31'b0, pready_w[0]}, 32'd0);
            check_eq("rst_prdata0", prdata_w[0], 32'd0);
            check_eq("rst_pslverr0", {31'b0, pslverr_w[0]}, 32'd0);
            check_eq("rst_pready1", {31'b0, pready_w[1]}, 32'd0);
        end
        reset = 1'b0; bus_zero();
        xfer(0, 32'hDEAD_CAC4, 1'b0, '0, rd, er, lat);
        check_eq("rst_reg1", rd, 32'd0);
        xfer(0, 32'hDEAD_CAFE, 1'b0, '0, rd, er, lat);
        check_eq("rst_reg15", rd, 32'd0);
        bus_idle(0);

        // Write then read with one wait state
        do_reset();
        xfer(0, 32'hDEAD_CAFE, 1'b1, 32'h0000_0001, rd, er, lat);
        check_eq("w15_latency", lat, 32'd2);
        check_eq("w15_err", {31'b0, er}, 32'd0);
        bus_idle(0);
        xfer(0, 32'hDEAD_CAFE, 1'b0, '0, rd, er, lat);
        check_eq("r15_data", rd, 32'h0000_0001);
        check_eq("r15_latency", lat, 32'd2);
        xfer(0, 32'hDEAD_CAC4, 1'b0, '0, rd, er, lat);
        check_eq("r1_after_two", rd, 32'd2);
        bus_idle(0);

        // Requester read/increment/write loop, back to back
        do_reset();
        for (int i = 0; i < 2; i++) begin
            xfer(0, 32'hDEAD_CAFE, 1'b0, '0, rd, er, lat);
            check_eq("loop_read", rd, 32'(i));
            check_eq("loop_read_err", {31'b0, er}, 32'd0);
            xfer(0, 32'hDEAD_CAFE, 1'b1, rd + 32'd1, rd, er, lat);
            check_eq("loop_write_err", {31'b0, er}, 32'd0);
        end
        xfer(0, 32'hDEAD_CAFE, 1'b0, '0, rd, er, lat);
        check_eq("loop_final", rd, 32'd2);

        // Error responses; counter is at 5 here
        xfer(0, 32'hDEAD_CAC0, 1'b1, 32'h0000_1234, rd, er, lat);
        check_eq("err_wr_id", {31'b0, er}, 32'd1);
        xfer(0, 32'hDEAD_CAC0, 1'b0, '0, rd, er, lat);
        check_eq("id_value", rd, 32'hA5B0_0016);
        check_eq("id_err", {31'b0, er}, 32'd0);
        xfer(0, 32'h0000_0000, 1'b0, '0, rd, er, lat);
        check_eq("oow_err", {31'b0, er}, 32'd1);
        check_eq("oow_data", rd, 32'd0);
        xfer(0, 32'hDEAD_CAC4, 1'b0, '0, rd, er, lat);
        check_eq("cnt_after_err", rd, 32'd8);
        bus_idle(0);

        // Abort in ST_WAIT during a write to reg2
        @(negedge clk);
        psel[0] = 1'b1; penable[0] = 1'b0; paddr[0] = 32'hDEAD_CAC8; pwrite[0] = 1'b1; pwdata[0] = 32'h0000_FFFF;
        @(negedge clk);
        penable[0] = 1'b1;
        check_eq("abort_state_wait", {30'b0, state_w[0]}, 32'd1);
        psel[0] = 1'b0; penable[0] = 1'b0;
        @(negedge clk);
        check_eq("abort_pready", {31'b0, pready_w[0]}, 32'd0);
        check_eq("abort_state_idle", {30'b0, state_w[0]}, 32'd0);
        xfer(0, 32'hDEAD_CAC8, 1'b0, '0, rd, er, lat);
        check_eq("abort_reg2", rd, 32'd0);
        xfer(0, 32'hDEAD_CAC4, 1'b0, '0, rd, er, lat);
        check_eq("abort_cnt", rd, 32'd10);
        bus_idle(0);

        // Reset while in ST_WAIT
        @(negedge clk);
        psel[0] = 1'b1; penable[0] = 1'b0; paddr[0] = 32'hDEAD_CACC; pwrite[0] = 1'b1; pwdata[0] = 32'h0000_BEEF;
        @(negedge clk);
        penable[0] = 1'b1; reset = 1'b1;
        @(negedge clk);
        check_eq("midrst_pready", {31'b0, pready_w[0]}, 32'd0);
        check_eq("midrst_prdata", prdata_w[0], 32'd0);
        check_eq("midrst_state", {30'b0, state_w[0]}, 32'd0);
        reset = 1'b0; bus_zero();
        xfer(0, 32'hDEAD_CACC, 1'b0, '0, rd, er, lat);
        check_eq("midrst_reg3", rd, 32'd0);
        xfer(0, 32'hDEAD_CAC4, 1'b0, '0, rd, er, lat);
        check_eq("midrst_cnt", rd, 32'd1);
        bus_idle(0);

        // Zero wait states, back to back, then counter wrap
        xfer(1, 32'hDEAD_CACC, 1'b1, 32'hCAFE_F00D, rd, er, lat);
        check_eq("zw_wr_latency", lat, 32'd1);
        check_eq("zw_wr_err", {31'b0, er}, 32'd0);
        xfer(1, 32'hDEAD_CACC, 1'b0, '0, rd, er, lat);
        check_eq("zw_rd_latency", lat, 32'd1);
        check_eq("zw_rd_data", rd, 32'hCAFE_F00D);
        bus_idle(1);
        force dut1.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut1.cnt_q;
        xfer(1, 32'hDEAD_CAC4, 1'b0, '0, rd, er, lat);
        check_eq("wrap_before", rd, 32'hFFFF_FFFF);
        xfer(1, 32'hDEAD_CAC4, 1'b0, '0, rd, er, lat);
        check_eq("wrap_after", rd, 32'd0);
        bus_idle(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
